// File: rtl/controle_mult4.sv
// Shift-and-add W x W unsigned multiplier controller driving an external W-bit adder.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips the iterations and finishes in one cycle.
module controle_mult4 #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] P,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    output logic           add_cin,
    input  logic [W-1:0]   add_s,
    input  logic           add_cout
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mcand_nxt;
    logic [W-1:0]   acc_hi;
    logic [W-1:0]   acc_nxt;
    logic [W-1:0]   mplr;
    logic [W-1:0]   mplr_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [2*W-1:0] p_nxt;
    logic           c;
    logic [W-1:0]   hi;
    logic [2*W:0]   sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            mplr   <= '0;
            cnt    <= '0;
            P      <= '0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            acc_hi <= acc_nxt;
            mplr   <= mplr_nxt;
            cnt    <= cnt_nxt;
            P      <= p_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mcand_nxt = mcand;
        acc_nxt   = acc_hi;
        mplr_nxt  = mplr;
        cnt_nxt   = cnt;
        p_nxt     = P;
        c         = 1'b0;
        hi        = acc_hi;
        sh        = '0;
        add_a     = '0;
        add_b     = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    mcand_nxt = A;
                    mplr_nxt  = B;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
`ifdef MULT_ZERO_BYPASS_EN
                    if (A == '0 || B == '0) begin
                        state_nxt = DONE;
                        p_nxt     = '0;
                    end else begin
                        state_nxt = CALC;
                    end
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                add_a = acc_hi;
                add_b = mcand;
                if (mplr[0]) begin
                    c  = add_cout;
                    hi = add_s;
                end
                // Carry, partial sum and multiplier shift right as one register.
                sh       = {c, hi, mplr} >> 1;
                acc_nxt  = sh[2*W-1:W];
                mplr_nxt = sh[W-1:0];
                cnt_nxt  = cnt + 1'b1;
                if (cnt == CW'(W - 1)) begin
                    state_nxt = DONE;
                    p_nxt     = {acc_nxt, mplr_nxt};
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign add_cin = 1'b0;

endmodule
